// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a shared RAM port: instruction fetch (read-only) and data access (read/write).
// Each access is held until the RAM reports DATA or ERROR, or until the optional watchdog expires.
module ram_arbiter #(
    parameter logic       DATA_PRIO = 1'b0,
    parameter logic [7:0] TIMEOUT   = 8'd32
) (
    input  logic        ram_clk,
    input  logic        nrst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_width,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [1:0]  ram_width,
    output logic [31:0] ram_store,
    input  logic [1:0]  ram_state,
    input  logic [31:0] ram_load
);

    typedef enum logic [1:0] {RAM_FREE, RAM_ADDR, RAM_DATA, RAM_ERROR} ram_state_t;
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    typedef enum logic {LAST_I, LAST_D} grant_t;

    state_t     state;
    state_t     state_next;
    grant_t     last_grant;
    ram_state_t ram_st;
    logic [7:0] tmo_cnt;
    logic       timeout_hit;
    logic       access_end;
    logic       access_err;

    assign ram_st      = ram_state_t'(ram_state);
    assign timeout_hit = (TIMEOUT != 8'd0) && (tmo_cnt == TIMEOUT - 8'd1);
    assign access_end  = (ram_st == RAM_DATA) || (ram_st == RAM_ERROR) || timeout_hit;
    // A DATA response wins over a watchdog expiry in the same cycle.
    assign access_err  = (ram_st != RAM_DATA) && ((ram_st == RAM_ERROR) || timeout_hit);

    assign i_rdata = ram_load;
    assign d_rdata = ram_load;

    always_ff @(posedge ram_clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            last_grant <= LAST_I;
            tmo_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values together.
            state <= state_next;
            if (state == IDLE) begin
                tmo_cnt <= '0;
                if (state_next == GNT_I) begin
                    last_grant <= LAST_I;
                end else if (state_next == GNT_D) begin
                    last_grant <= LAST_D;
                end
            end else if (tmo_cnt != 8'hFF) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first, so no branch can leave an output unassigned and infer a latch.
        state_next = state;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_width  = '0;
        ram_store  = '0;
        i_done     = 1'b0;
        i_err      = 1'b0;
        d_done     = 1'b0;
        d_err      = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    state_next = (DATA_PRIO || last_grant == LAST_I) ? GNT_D : GNT_I;
                end else if (i_req) begin
                    state_next = GNT_I;
                end else if (d_req) begin
                    state_next = GNT_D;
                end
            end
            GNT_I: begin
                ram_ren   = 1'b1;
                ram_addr  = i_addr;
                ram_width = 2'b10;
                i_done    = access_end;
                i_err     = access_err;
                if (access_end) begin
                    state_next = IDLE;
                end
            end
            GNT_D: begin
                ram_ren   = ~d_wen;
                ram_wen   = d_wen;
                ram_addr  = d_addr;
                ram_width = d_width;
                ram_store = d_wdata;
                d_done    = access_end;
                d_err     = access_err;
                if (access_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: two instances (round-robin with a short watchdog, data-priority
// without watchdog) share one behavioural RAM; expectations come from a transaction-level model.
module tb_ram_arbiter;

    localparam logic [1:0] RS_FREE = 2'd0, RS_ADDR = 2'd1, RS_DATA = 2'd2, RS_ERROR = 2'd3;

    logic        clk = 1'b0;
    logic        nrst;
    logic        sel;
    logic        i_req, d_req, d_wen;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [1:0]  d_width;
    logic [1:0]  ram_state;
    logic [31:0] ram_load;

    logic        a_i_done, a_i_err, a_d_done, a_d_err, a_ren, a_wen;
    logic [31:0] a_i_rdata, a_d_rdata, a_addr, a_store;
    logic [1:0]  a_width;
    logic        b_i_done, b_i_err, b_d_done, b_d_err, b_ren, b_wen;
    logic [31:0] b_i_rdata, b_d_rdata, b_addr, b_store;
    logic [1:0]  b_width;

    logic        i_done, i_err, d_done, d_err, ram_ren, ram_wen;
    logic [31:0] i_rdata, d_rdata, ram_addr, ram_store;
    logic [1:0]  ram_width;
    logic [67:0] act_bus;
    logic [71:0] a_all, b_all;

    int          checks = 0;
    int          errors = 0;
    int          ram_lat, ram_mode, lat_cnt;
    bit          model_last [2];
    logic [31:0] last_d_rdata;
    logic [7:0]  mem [0:1023];
    logic [7:0]  ref_mem [0:1023];
    bit          mem_loaded = 1'b0;
    logic [9:0]  ma;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_PRIO(1'b0), .TIMEOUT(8'd4)) dut_a (
        .ram_clk(clk), .nrst(nrst),
        .i_req(i_req & ~sel), .i_addr(i_addr), .i_done(a_i_done), .i_err(a_i_err), .i_rdata(a_i_rdata),
        .d_req(d_req & ~sel), .d_wen(d_wen), .d_addr(d_addr), .d_width(d_width), .d_wdata(d_wdata),
        .d_done(a_d_done), .d_err(a_d_err), .d_rdata(a_d_rdata),
        .ram_ren(a_ren), .ram_wen(a_wen), .ram_addr(a_addr), .ram_width(a_width), .ram_store(a_store),
        .ram_state(ram_state), .ram_load(ram_load)
    );

    ram_arbiter #(.DATA_PRIO(1'b1), .TIMEOUT(8'd0)) dut_b (
        .ram_clk(clk), .nrst(nrst),
        .i_req(i_req & sel), .i_addr(i_addr), .i_done(b_i_done), .i_err(b_i_err), .i_rdata(b_i_rdata),
        .d_req(d_req & sel), .d_wen(d_wen), .d_addr(d_addr), .d_width(d_width), .d_wdata(d_wdata),
        .d_done(b_d_done), .d_err(b_d_err), .d_rdata(b_d_rdata),
        .ram_ren(b_ren), .ram_wen(b_wen), .ram_addr(b_addr), .ram_width(b_width), .ram_store(b_store),
        .ram_state(ram_state), .ram_load(ram_load)
    );

    assign i_done    = sel ? b_i_done  : a_i_done;
    assign i_err     = sel ? b_i_err   : a_i_err;
    assign i_rdata   = sel ? b_i_rdata : a_i_rdata;
    assign d_done    = sel ? b_d_done  : a_d_done;
    assign d_err     = sel ? b_d_err   : a_d_err;
    assign d_rdata   = sel ? b_d_rdata : a_d_rdata;
    assign ram_ren   = sel ? b_ren     : a_ren;
    assign ram_wen   = sel ? b_wen     : a_wen;
    assign ram_addr  = sel ? b_addr    : a_addr;
    assign ram_width = sel ? b_width   : a_width;
    assign ram_store = sel ? b_store   : a_store;
    assign act_bus   = {ram_ren, ram_wen, ram_addr, ram_width, ram_store};
    assign a_all     = {a_ren, a_wen, a_addr, a_width, a_store, a_i_done, a_i_err, a_d_done, a_d_err};
    assign b_all     = {b_ren, b_wen, b_addr, b_width, b_store, b_i_done, b_i_err, b_d_done, b_d_err};
    assign ma        = ram_addr[9:0];

    // Behavioural RAM: DATA arrives max(LAT,1) enabled cycles after the first enable; mode 1 stalls, mode 2 errors.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ram_state <= RS_FREE;
            lat_cnt   <= 0;
            ram_load  <= '0;
            if (!mem_loaded) begin
                for (int k = 0; k < 1024; k++) mem[k] <= 8'(k * 29 + 7);
                mem_loaded <= 1'b1;
            end
        end else if (ram_ren || ram_wen) begin
            lat_cnt <= lat_cnt + 1;
            if (ram_mode == 1) begin
                ram_state <= RS_ADDR;
            end else if (ram_mode == 2) begin
                ram_state <= RS_ERROR;
            end else if (ram_state == RS_DATA) begin
                ram_state <= RS_DATA;
            end else if (lat_cnt + 1 >= ((ram_lat > 1) ? ram_lat : 1)) begin
                ram_state <= RS_DATA;
                if (ram_wen) begin
                    mem[ma] <= ram_store[7:0];
                    if (ram_width != 2'd0) mem[ma + 10'd1] <= ram_store[15:8];
                    if (ram_width == 2'd2) begin
                        mem[ma + 10'd2] <= ram_store[23:16];
                        mem[ma + 10'd3] <= ram_store[31:24];
                    end
                end else begin
                    case (ram_width)
                        2'd0:    ram_load <= {24'h0, mem[ma]};
                        2'd1:    ram_load <= {16'h0, mem[ma + 10'd1], mem[ma]};
                        default: ram_load <= {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
                    endcase
                end
            end else begin
                ram_state <= RS_ADDR;
            end
        end else begin
            ram_state <= RS_FREE;
            lat_cnt   <= 0;
        end
    end

    function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [1:0] w);
        logic [9:0] m;
        m = a[9:0];
        case (w)
            2'd0:    return {24'h0, ref_mem[m]};
            2'd1:    return {16'h0, ref_mem[m + 10'd1], ref_mem[m]};
            default: return {ref_mem[m + 10'd3], ref_mem[m + 10'd2], ref_mem[m + 10'd1], ref_mem[m]};
        endcase
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [1:0] w, input logic [31:0] v);
        logic [9:0] m;
        m = a[9:0];
        ref_mem[m] = v[7:0];
        if (w != 2'd0) ref_mem[m + 10'd1] = v[15:8];
        if (w == 2'd2) begin
            ref_mem[m + 10'd2] = v[23:16];
            ref_mem[m + 10'd3] = v[31:24];
        end
    endtask

    // Expected RAM-side bus: who 0 = nobody granted, 1 = fetch, 2 = data.
    function automatic logic [67:0] exp_bus(input int who);
        case (who)
            1:       return {1'b1, 1'b0, i_addr, 2'b10, 32'h0};
            2:       return {~d_wen, d_wen, d_addr, d_width, d_wdata};
            default: return 68'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (act_bus !== 68'h0 || i_done !== 1'b0 || d_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: bus %h i_done %b d_done %b, expected all zero", name, act_bus, i_done, d_done);
        end
    endtask

    // One transaction round: requests raised together in IDLE, each dropped at its own done.
    task automatic run_round(input bit want_i, input bit want_d);
        int lat_e, first, second, ci, cd, cmax, who;
        logic [31:0] exp_rd;
        lat_e  = (ram_lat > 1) ? ram_lat : 1;
        if (want_i && want_d) first = (sel || !model_last[sel]) ? 2 : 1;
        else                  first = want_d ? 2 : 1;
        second = (want_i && want_d) ? 3 - first : 0;
        ci = -1;
        cd = -1;
        if (first == 1) ci = 1 + lat_e; else cd = 1 + lat_e;
        if (second == 1) ci = 3 + 2 * lat_e;
        if (second == 2) cd = 3 + 2 * lat_e;
        cmax  = (second != 0) ? 3 + 2 * lat_e : 1 + lat_e;
        i_req = want_i;
        d_req = want_d;
        for (int c = 1; c <= cmax; c++) begin
            tick();
            who = (c <= 1 + lat_e) ? first : ((c >= 3 + lat_e) ? second : 0);
            checks++;
            if (act_bus !== exp_bus(who)) begin
                errors++;
                $display("FAIL bus cycle %0d: got %h expected %h", c, act_bus, exp_bus(who));
            end
            checks++;
            if ({i_done, d_done} !== {c == ci, c == cd}) begin
                errors++;
                $display("FAIL done cycle %0d: got i%b d%b expected i%b d%b", c, i_done, d_done, c == ci, c == cd);
            end
            if (i_done && c == ci) begin
                exp_rd = ref_rd(i_addr, 2'd2);
                checks++;
                if (i_err !== 1'b0 || i_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL fetch data: got %h err %b expected %h err 0", i_rdata, i_err, exp_rd);
                end
                i_req = 1'b0;
            end
            if (d_done && c == cd) begin
                exp_rd = d_wen ? d_rdata : ref_rd(d_addr, d_width);
                checks++;
                if (d_err !== 1'b0 || d_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL data access: got %h err %b expected %h err 0", d_rdata, d_err, exp_rd);
                end
                if (d_wen) ref_wr(d_addr, d_width, d_wdata);
                else       last_d_rdata = d_rdata;
                d_req = 1'b0;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        model_last[sel] = (second != 0) ? (second == 2) : (first == 2);
        tick();
        check_idle("round_end_idle");
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (a_all !== 72'h0) begin
            errors++;
            $display("FAIL reset_a: got %h expected 0", a_all);
        end
        checks++;
        if (b_all !== 72'h0) begin
            errors++;
            $display("FAIL reset_b: got %h expected 0", b_all);
        end
        #3 nrst = 1'b1;
        tick();
        check_idle("post_reset_idle");
    endtask

    task automatic test_fetch();
        sel     = 1'b0;
        ram_lat = 0;
        i_addr  = 32'h100;
        run_round(1'b1, 1'b0);
    endtask

    task automatic test_round_robin();
        bit exp_d, idle_next;
        int ndone;
        sel     = 1'b0;
        ram_lat = 0;
        d_wen   = 1'b0;
        d_addr  = 32'h120;
        d_width = 2'd2;
        i_addr  = 32'h104;
        exp_d     = !model_last[0];
        idle_next = 1'b0;
        ndone     = 0;
        i_req     = 1'b1;
        d_req     = 1'b1;
        for (int c = 0; c < 60 && ndone < 4; c++) begin
            tick();
            if (idle_next) begin
                check_idle("rr_gap");
                idle_next = 1'b0;
            end
            if (i_done || d_done) begin
                checks++;
                if ({d_done, i_done} !== (exp_d ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL rr_order grant %0d: got d%b i%b expected d%b", ndone, d_done, i_done, exp_d);
                end
                ndone++;
                exp_d     = !exp_d;
                idle_next = 1'b1;
                if (ndone == 4) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                end
            end
        end
        checks++;
        if (ndone != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d grants expected 4", ndone);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        model_last[0] = !exp_d;
        tick();
        check_idle("rr_end_idle");
    endtask

    task automatic test_store_load();
        sel     = 1'b0;
        ram_lat = 0;
        d_wen   = 1'b1;
        d_width = 2'd0;
        d_addr  = 32'h203;
        d_wdata = 32'h0000_00AB;
        run_round(1'b0, 1'b1);
        d_wen        = 1'b0;
        last_d_rdata = 32'hFFFF_FFFF;
        run_round(1'b0, 1'b1);
        checks++;
        if (last_d_rdata !== 32'h0000_00AB) begin
            errors++;
            $display("FAIL byte_load: got %h expected 000000ab", last_d_rdata);
        end
    endtask

    task automatic test_timeout();
        sel      = 1'b0;
        ram_lat  = 0;
        ram_mode = 1;
        d_wen    = 1'b0;
        d_addr   = 32'h110;
        d_width  = 2'd2;
        d_req    = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (d_done !== (c == 4) || (c == 4 && d_err !== 1'b1)) begin
                errors++;
                $display("FAIL timeout cycle %0d: got done %b err %b expected done %b err 1", c, d_done, d_err, c == 4);
            end
        end
        d_req    = 1'b0;
        ram_mode = 0;
        model_last[0] = 1'b1;
        tick();
        check_idle("timeout_idle");
        ram_mode = 2;
        i_addr   = 32'h108;
        i_req    = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if (i_done !== (c == 2) || (c == 2 && i_err !== 1'b1)) begin
                errors++;
                $display("FAIL ram_error cycle %0d: got done %b err %b expected done %b err 1", c, i_done, i_err, c == 2);
            end
        end
        i_req    = 1'b0;
        ram_mode = 0;
        model_last[0] = 1'b0;
        tick();
        check_idle("error_idle");
    endtask

    task automatic test_prio();
        int nd, ni;
        sel     = 1'b1;
        ram_lat = 1;
        d_wen   = 1'b0;
        d_addr  = 32'h130;
        d_width = 2'd1;
        i_addr  = 32'h10C;
        nd      = 0;
        ni      = 0;
        i_req   = 1'b1;
        d_req   = 1'b1;
        for (int c = 0; c < 80 && ni == 0; c++) begin
            tick();
            if (i_done || d_done) begin
                checks++;
                if ({i_done, d_done} !== ((nd < 3) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL prio_order after %0d data grants: got i%b d%b", nd, i_done, d_done);
                end
                if (d_done) begin
                    nd++;
                    if (nd == 3) d_req = 1'b0;
                end
                if (i_done) begin
                    ni++;
                    i_req = 1'b0;
                end
            end
        end
        checks++;
        if (nd != 3 || ni != 1) begin
            errors++;
            $display("FAIL prio_count: got d %0d i %0d expected d 3 i 1", nd, ni);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        model_last[1] = 1'b0;
        tick();
        check_idle("prio_idle");
    endtask

    task automatic test_no_watchdog();
        bit got;
        logic [31:0] exp_rd;
        sel      = 1'b1;
        ram_lat  = 0;
        ram_mode = 1;
        d_wen    = 1'b0;
        d_addr   = 32'h134;
        d_width  = 2'd2;
        d_req    = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            checks++;
            if (d_done !== 1'b0) begin
                errors++;
                $display("FAIL no_watchdog cycle %0d: got d_done %b expected 0", c, d_done);
            end
        end
        ram_mode = 0;
        exp_rd   = ref_rd(d_addr, d_width);
        got      = 1'b0;
        for (int c = 0; c < 4 && !got; c++) begin
            tick();
            if (d_done) begin
                got = 1'b1;
                checks++;
                if (d_err !== 1'b0 || d_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL late_data: got %h err %b expected %h err 0", d_rdata, d_err, exp_rd);
                end
                d_req = 1'b0;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL late_data_done: got no done expected one within 4 cycles");
        end
        d_req = 1'b0;
        model_last[1] = 1'b1;
        tick();
        check_idle("no_watchdog_idle");
    endtask

    task automatic test_reset_mid_grant();
        sel     = 1'b0;
        ram_lat = 3;
        d_wen   = 1'b0;
        d_addr  = 32'h118;
        d_width = 2'd2;
        d_req   = 1'b1;
        tick();
        tick();
        checks++;
        if (ram_ren !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant_enable: got %b expected 1", ram_ren);
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (ram_ren !== 1'b0 || ram_wen !== 1'b0 || d_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got ren %b wen %b done %b expected 0 0 0", ram_ren, ram_wen, d_done);
        end
        d_req = 1'b0;
        #1 nrst = 1'b1;
        model_last[0] = 1'b0;
        model_last[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_idle("after_reset_quiet");
        end
        ram_lat = 0;
        i_addr  = 32'h104;
        run_round(1'b1, 1'b0);
    endtask

    task automatic test_random(input int rounds);
        int pat;
        for (int n = 0; n < rounds; n++) begin
            sel     = 1'($urandom_range(0, 1));
            ram_lat = int'($urandom_range(0, 3));
            pat     = int'($urandom_range(1, 3));
            i_addr  = 32'h100 + ($urandom_range(0, 15) << 2);
            d_width = 2'($urandom_range(0, 2));
            d_addr  = (32'h100 + $urandom_range(0, 63)) & ~((32'd1 << d_width) - 32'd1);
            d_wen   = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
            run_round(pat[0], pat[1]);
        end
    endtask

    initial begin
        nrst     = 1'b0;
        sel      = 1'b0;
        i_req    = 1'b0;
        d_req    = 1'b0;
        d_wen    = 1'b0;
        i_addr   = '0;
        d_addr   = '0;
        d_width  = '0;
        d_wdata  = '0;
        ram_lat  = 0;
        ram_mode = 0;
        model_last[0] = 1'b0;
        model_last[1] = 1'b0;
        for (int k = 0; k < 1024; k++) ref_mem[k] = 8'(k * 29 + 7);
        test_reset();
        test_fetch();
        test_round_robin();
        test_store_load();
        test_timeout();
        test_prio();
        test_no_watchdog();
        test_reset_mid_grant();
        test_random(80);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
